sys_bus_bridge: RTL and testbench

- Parametrised, registered system-bus bridge between the CPU data port and NUM_DEV memory-mapped slaves (DM, timers, interrupt generator, future UART).
- Decodes each CPU request against per-slot address windows and drives a one-hot slave select.
- Holds the transaction until the slave acknowledges, then returns read data with a one-cycle ack pulse.
- Flags unmapped accesses and slave timeouts as bus errors, with the faulting address latched for the CP0 exception path.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_addr_decode.sv | 29 ++
 rtl/sys_bus_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_sys_bus_bridge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus bridge: FSM state encoding, the default
// memory map, and the timeout-counter width check.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam logic [31:0] DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT  = 32'h0000_2fff;
  localparam logic [31:0] TC0_BASE  = 32'h0000_7f00;
  localparam logic [31:0] TC0_LIMIT = 32'h0000_7f0b;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7f10;
  localparam logic [31:0] TC1_LIMIT = 32'h0000_7f1b;
  localparam logic [31:0] IG_BASE   = 32'h0000_7f20;
  localparam logic [31:0] IG_LIMIT  = 32'h0000_7f2b;

  // True when a to_w-bit counter can reach timeout-1 and timeout is usable.
  function automatic bit to_w_fits(input int unsigned to_w, input int unsigned timeout);
    return (timeout >= 32'd2) && (to_w <= 32'd31) && (64'(timeout) <= (64'd1 << to_w));
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: one-hot hit vector with lowest-index priority
// on overlapping windows, plus a miss flag for unmapped addresses.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned              NUM_DEV   = 3,
  parameter logic [NUM_DEV*32-1:0]    DEV_BASE  = {TC1_BASE, TC0_BASE, DM_BASE},
  parameter logic [NUM_DEV*32-1:0]    DEV_LIMIT = {TC1_LIMIT, TC0_LIMIT, DM_LIMIT}
) (
  input  logic [31:0]        addr,
  output logic [NUM_DEV-1:0] hit,
  output logic               miss
);

  logic [NUM_DEV-1:0] raw_hit_s;

  // Per-slot inclusive window compare.
  always_comb begin
    raw_hit_s = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      raw_hit_s[i] = (addr >= DEV_BASE[32*i +: 32]) && (addr <= DEV_LIMIT[32*i +: 32]);
    end
  end

  // Isolate the lowest set bit so the lowest-index window wins.
  assign hit  = raw_hit_s & (~raw_hit_s + NUM_DEV'(1));
  assign miss = ~|raw_hit_s;

endmodule

// File: rtl/sys_bus_bridge.sv
// Registered CPU-to-slave system-bus bridge with address decode, ack/timeout
// handling and error-address capture. Optional posted writes: BRIDGE_WRITE_POST_EN.
module sys_bus_bridge
  import bus_pkg::*;
#(
  parameter int unsigned           NUM_DEV   = 3,
  parameter logic [NUM_DEV*32-1:0] DEV_BASE  = {TC1_BASE, TC0_BASE, DM_BASE},
  parameter logic [NUM_DEV*32-1:0] DEV_LIMIT = {TC1_LIMIT, TC0_LIMIT, DM_LIMIT},
  parameter int unsigned           TIMEOUT   = 16,
  parameter int unsigned           TO_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  input  logic [3:0]            cpu_byteen,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic [31:0]           cpu_rdata,
  output logic [31:0]           err_addr,
`ifdef BRIDGE_WRITE_POST_EN
  output logic                  err_addr_vld,
`endif
  output logic [NUM_DEV-1:0]    dev_sel,
  output logic [31:0]           dev_addr,
  output logic [3:0]            dev_byteen,
  output logic [31:0]           dev_wdata,
  input  logic [NUM_DEV*32-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]    dev_ack
);

  if (!to_w_fits(TO_W, TIMEOUT)) begin : g_bad_to_w
    $error("sys_bus_bridge: TO_W too narrow for TIMEOUT or TIMEOUT < 2");
  end

  bus_state_e         state_r, state_d;
  logic               cpu_ack_r, cpu_ack_d;
  logic               cpu_err_r, cpu_err_d;
  logic [31:0]        cpu_rdata_r, cpu_rdata_d;
  logic [31:0]        err_addr_r, err_addr_d;
  logic [NUM_DEV-1:0] dev_sel_r, dev_sel_d;
  logic [31:0]        dev_addr_r, dev_addr_d;
  logic [3:0]         dev_byteen_r, dev_byteen_d;
  logic [31:0]        dev_wdata_r, dev_wdata_d;
  logic [TO_W-1:0]    to_cnt_r, to_cnt_d;
  logic [NUM_DEV-1:0] hit_s;
  logic               miss_s;
  logic               ack_sel_s;
  logic [31:0]        rdata_sel_s;
`ifdef BRIDGE_WRITE_POST_EN
  logic               posted_r, posted_d;
  logic               err_vld_r, err_vld_d;
`endif

  bus_addr_decode #(
    .NUM_DEV   (NUM_DEV),
    .DEV_BASE  (DEV_BASE),
    .DEV_LIMIT (DEV_LIMIT)
  ) u_decode (
    .addr (cpu_addr),
    .hit  (hit_s),
    .miss (miss_s)
  );

  // Only the selected slot's ack and read data are visible; others are masked.
  always_comb begin
    rdata_sel_s = 32'h0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      rdata_sel_s = rdata_sel_s | (dev_rdata[32*i +: 32] & {32{dev_sel_r[i]}});
    end
  end
  assign ack_sel_s = |(dev_ack & dev_sel_r);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_r;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_r;
    err_addr_d   = err_addr_r;
    dev_sel_d    = dev_sel_r;
    dev_addr_d   = dev_addr_r;
    dev_byteen_d = dev_byteen_r;
    dev_wdata_d  = dev_wdata_r;
    to_cnt_d     = to_cnt_r;
`ifdef BRIDGE_WRITE_POST_EN
    posted_d     = posted_r;
    err_vld_d    = err_vld_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          dev_addr_d   = cpu_addr;
          dev_byteen_d = cpu_byteen;
          dev_wdata_d  = cpu_wdata;
          to_cnt_d     = '0;
          if (miss_s) begin
            state_d     = ST_RESP;
            cpu_ack_d   = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = 32'h0;
            err_addr_d  = cpu_addr;
          end else begin
            state_d   = ST_BUSY;
            dev_sel_d = hit_s;
`ifdef BRIDGE_WRITE_POST_EN
            posted_d  = (cpu_byteen != 4'b0000);
            cpu_ack_d = (cpu_byteen != 4'b0000);
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ack_sel_s) begin
          dev_sel_d   = '0;
          to_cnt_d    = '0;
          state_d     = ST_RESP;
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = (dev_byteen_r != 4'b0000) ? 32'h0 : rdata_sel_s;
`ifdef BRIDGE_WRITE_POST_EN
          // A posted write was already acknowledged to the CPU.
          if (posted_r) begin
            state_d     = ST_IDLE;
            cpu_ack_d   = 1'b0;
            cpu_rdata_d = cpu_rdata_r;
            posted_d    = 1'b0;
          end else begin
            posted_d    = 1'b0;
          end
`endif
        end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
          dev_sel_d   = '0;
          to_cnt_d    = '0;
          err_addr_d  = dev_addr_r;
          state_d     = ST_RESP;
          cpu_ack_d   = 1'b1;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = 32'h0;
`ifdef BRIDGE_WRITE_POST_EN
          if (posted_r) begin
            state_d     = ST_IDLE;
            cpu_ack_d   = 1'b0;
            cpu_err_d   = 1'b0;
            cpu_rdata_d = cpu_rdata_r;
            err_vld_d   = 1'b1;
            posted_d    = 1'b0;
          end else begin
            posted_d    = 1'b0;
          end
`endif
        end else begin
          to_cnt_d = to_cnt_r + TO_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        dev_sel_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cpu_ack_r    <= 1'b0;
      cpu_err_r    <= 1'b0;
      cpu_rdata_r  <= 32'h0;
      err_addr_r   <= 32'h0;
      dev_sel_r    <= '0;
      dev_addr_r   <= 32'h0;
      dev_byteen_r <= 4'h0;
      dev_wdata_r  <= 32'h0;
      to_cnt_r     <= '0;
`ifdef BRIDGE_WRITE_POST_EN
      posted_r     <= 1'b0;
      err_vld_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_d;
      cpu_ack_r    <= cpu_ack_d;
      cpu_err_r    <= cpu_err_d;
      cpu_rdata_r  <= cpu_rdata_d;
      err_addr_r   <= err_addr_d;
      dev_sel_r    <= dev_sel_d;
      dev_addr_r   <= dev_addr_d;
      dev_byteen_r <= dev_byteen_d;
      dev_wdata_r  <= dev_wdata_d;
      to_cnt_r     <= to_cnt_d;
`ifdef BRIDGE_WRITE_POST_EN
      posted_r     <= posted_d;
      err_vld_r    <= err_vld_d;
`endif
    end
  end

  assign cpu_ack    = cpu_ack_r;
  assign cpu_err    = cpu_err_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign err_addr   = err_addr_r;
  assign dev_sel    = dev_sel_r;
  assign dev_addr   = dev_addr_r;
  assign dev_byteen = dev_byteen_r;
  assign dev_wdata  = dev_wdata_r;
`ifdef BRIDGE_WRITE_POST_EN
  assign err_addr_vld = err_vld_r;
`endif

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Scoreboard bench for sys_bus_bridge: directed cases then randomized traffic
// checked against a transaction-level model of decode, wait states and timeout.
module tb_sys_bus_bridge;

  localparam int NUM_DEV = 3;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 99;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  cpu_req = 1'b0;
  logic [31:0]           cpu_addr = 32'h0;
  logic [3:0]            cpu_byteen = 4'h0;
  logic [31:0]           cpu_wdata = 32'h0;
  logic                  cpu_ack, cpu_err;
  logic [31:0]           cpu_rdata, err_addr;
  logic [NUM_DEV-1:0]    dev_sel;
  logic [31:0]           dev_addr, dev_wdata;
  logic [3:0]            dev_byteen;
  logic [NUM_DEV*32-1:0] dev_rdata = '0;
  logic [NUM_DEV-1:0]    dev_ack = '0;

  sys_bus_bridge dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .err_addr(err_addr),
    .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_byteen(dev_byteen),
    .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] eaddr;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int ack_seen = 0;
  logic [31:0] last_err = 32'h0;

  logic [31:0] map_base [NUM_DEV] = '{32'h0000_0000, 32'h0000_7f00, 32'h0000_7f10};
  logic [31:0] map_lim  [NUM_DEV] = '{32'h0000_2fff, 32'h0000_7f0b, 32'h0000_7f1b};

  function automatic int model_slot(input logic [31:0] a);
    for (int i = 0; i < NUM_DEV; i++)
      if (a >= map_base[i] && a <= map_lim[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cpu_ack pops one expected response.
  always @(negedge clk) begin
    if (!reset && cpu_ack) begin
      ack_seen++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 128'(cpu_ack), 128'(1'b0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cpu_err", 128'(cpu_err), 128'(e.err));
        check("cpu_rdata", 128'(cpu_rdata), 128'(e.rdata));
        check("err_addr", 128'(err_addr), 128'(e.eaddr));
        check("ack_latency", 128'(cyc), 128'(e.ack_cyc));
      end
    end
  end

  task automatic do_txn(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input int w, input logic [31:0] d);
    int   slot, busy, exp_busy, lat;
    bit   seen, first;
    exp_t e;
    slot = model_slot(a);
    @(negedge clk);
    for (int i = 0; i < NUM_DEV; i++) dev_rdata[32*i +: 32] = $urandom;
    if (slot >= 0) dev_rdata[32*slot +: 32] = d;
    cpu_req = 1'b1; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
    if (slot < 0) begin
      e.err = 1'b1; e.rdata = 32'h0; lat = 1; exp_busy = 0;
    end else if (w < TIMEOUT) begin
      e.err = 1'b0; e.rdata = (be == 4'h0) ? d : 32'h0; lat = w + 2; exp_busy = w + 1;
    end else begin
      e.err = 1'b1; e.rdata = 32'h0; lat = TIMEOUT + 1; exp_busy = TIMEOUT;
    end
    if (e.err) last_err = a;
    e.eaddr = last_err;
    e.ack_cyc = cyc + lat;
    sb.push_back(e);
    busy = 0; seen = 1'b0; first = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      dev_ack = '0;
      if (cpu_ack) begin
        seen = 1'b1;
        cpu_req = 1'b0;
      end else if (dev_sel != '0) begin
        if (first) begin
          first = 1'b0;
          check("dev_latch", {dev_sel, dev_addr, dev_byteen, dev_wdata},
                {(slot >= 0) ? NUM_DEV'(1 << slot) : NUM_DEV'(0), a, be, wd});
        end
        if (busy == w) dev_ack = dev_sel;
        dev_ack = dev_ack | (NUM_DEV'($urandom) & ~dev_sel);
        busy++;
      end else begin
        busy = busy;
      end
    end
    cpu_req = 1'b0;
    dev_ack = '0;
    if (!seen) check("ack_timeout", 128'(seen), 128'(1'b1));
    check("dev_sel_cycles", 128'(busy), 128'(exp_busy));
  endtask

  task automatic reset_mid_busy();
    int acks_before;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_7f04; cpu_byteen = 4'h0;
    @(negedge clk);
    cpu_req = 1'b0;
    check("mid_busy_sel", 128'(dev_sel), 128'(3'b010));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_reset_outs", {cpu_ack, cpu_err, cpu_rdata, err_addr, dev_sel, dev_addr, dev_byteen, dev_wdata},
          128'(0));
    last_err = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    acks_before = ack_seen;
    repeat (20) @(negedge clk);
    check("no_ack_after_abort", 128'(ack_seen - acks_before), 128'(0));
  endtask

  logic [31:0] edge_addrs [8] = '{32'h0000_2fff, 32'h0000_3000, 32'h0000_7eff, 32'h0000_7f0b,
                                  32'h0000_7f0c, 32'h0000_7f10, 32'h0000_7f1b, 32'hffff_ffff};

  initial begin
    #1;
    check("reset_outs", {cpu_ack, cpu_err, cpu_rdata, err_addr, dev_sel, dev_addr, dev_byteen, dev_wdata},
          128'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    do_txn(32'h0000_1004, 4'h0, 32'h0, 0, 32'hdead_beef);
    do_txn(32'h0000_7f14, 4'hf, 32'h5, 3, 32'h1234_5678);
    do_txn(32'h0000_7f0c, 4'h0, 32'h0, 0, 32'h0);
    do_txn(32'h0000_7f00, 4'h0, 32'h0, NEVER, 32'h0);
    reset_mid_busy();
    do_txn(32'h0000_7f00, 4'h0, 32'h0, TIMEOUT - 1, 32'hcafe_f00d);
    for (int i = 0; i < 8; i++) do_txn(edge_addrs[i], 4'h0, 32'h0, i, $urandom);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [3:0]  be;
      int          w;
      case ($urandom_range(0, 5))
        0: a = $urandom;
        1: a = $urandom_range(0, 32'h2fff);
        2: a = 32'h7f00 + $urandom_range(0, 11);
        3: a = 32'h7f10 + $urandom_range(0, 11);
        4: a = edge_addrs[$urandom_range(0, 7)];
        default: a = 32'h7f00 + $urandom_range(0, 47);
      endcase
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      w  = $urandom_range(0, 19);
      do_txn(a, be, $urandom, w, $urandom);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
